// File: rtl/seq_detector_param.sv
// Run-time programmable Moore sequence detector: registered pulse when the last len sampled bits equal pattern.
// Optional saturating match counter is built only when SEQDET_MATCH_COUNT_EN is defined.
module seq_detector_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
  parameter int                 DEFAULT_LEN     = 4,
  parameter int                 COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               sequence_valid,
  input  logic               overlap_en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               count_clear,
  output logic               detector_out,
  output logic [COUNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] history, history_next, pattern, len_mask;
  logic [LEN_W-1:0]   len, fill, fill_next, eff_len;
  logic               match;

  // Zero length disables detection; oversized lengths clamp to the history depth.
  always_comb begin
    eff_len = cfg_len;
    if (cfg_len > MAX_LEN_L) eff_len = MAX_LEN_L;
  end

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len));
  end

  // Match is judged on the post-shift history so the pulse lands one cycle after the last bit.
  always_comb begin
    history_next = history;
    fill_next    = fill;
    match        = 1'b0;
    if (sequence_valid) begin
      history_next = {history[MAX_LEN-2:0], sequence_in};
      fill_next    = (fill >= MAX_LEN_L) ? MAX_LEN_L : fill + 1'b1;
      match        = (len != '0) && (fill_next >= len) &&
                     ((history_next & len_mask) == (pattern & len_mask));
      if (match && !overlap_en) fill_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history      <= '0;
      fill         <= '0;
      detector_out <= 1'b0;
      pattern      <= DEFAULT_PATTERN;
      len          <= LEN_W'(DEFAULT_LEN);
    end else if (cfg_load) begin
      history      <= '0;
      fill         <= '0;
      detector_out <= 1'b0;
      pattern      <= cfg_pattern;
      len          <= eff_len;
    end else begin
      history      <= history_next;
      fill         <= fill_next;
      detector_out <= match;
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (cfg_load || count_clear) begin
      count_q <= '0;
    end else if (match && (count_q != {COUNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`else
  logic unused_count_clear;
  assign unused_count_clear = count_clear;
  assign match_count        = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, run-time programmable successor to the team's fixed-pattern Moore sequence detector.
- Samples a serial bit stream and asserts a registered Moore-style output when the last N bits match a programmable pattern of length 1..MAX_LEN.
- Supports overlapping and non-overlapping modes, a per-bit valid qualifier, and an optional saturating detection counter.
- Sits in the serial-stream front end in place of single-pattern detectors.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived; do not override).
- DEFAULT_PATTERN, 8'b0000_1011: pattern loaded at reset, right-aligned.
- DEFAULT_LEN, 4: length loaded at reset.
- COUNT_W, 8: detection counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- sequence_in  in  1  serial data bit.
- sequence_valid  in  1  sequence_in is sampled only when high.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_load  in  1  one-cycle strobe: load cfg_pattern/cfg_len.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length.
- count_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  registered detection pulse.
- match_count  out  COUNT_W  saturating detection count.

Behaviour:
- Reset asserted (low), asynchronous:
  - history = 0, fill = 0, detector_out = 0, match_count = 0.
  - pattern = DEFAULT_PATTERN, len = DEFAULT_LEN.
  - Applies mid-stream; any partial match is discarded.
- Config load:
  - On a clock edge with cfg_load=1, latch cfg_pattern and the effective length, and clear history, fill, detector_out and match_count.
  - Effective length: cfg_len=0 disables detection (detector_out stays 0); cfg_len>MAX_LEN is clamped to MAX_LEN.
  - cfg_load has priority over sequence_valid; a bit presented in the load cycle is discarded.
- Sampling, on an edge with sequence_valid=1 and cfg_load=0:
  - history <= {history[MAX_LEN-2:0], sequence_in}.
  - fill <= min(fill+1, MAX_LEN).
  - With sequence_valid=0, history, fill and counter hold and detector_out <= 0.
- Match condition, evaluated on the updated history: (fill_next >= len) and (history_next[len-1:0] == pattern[len-1:0]).
- Moore output:
  - detector_out <= match, registered.
  - Goes high in the cycle after the edge that samples the final pattern bit; high for exactly one cycle per detection.
  - Back-to-back detections give consecutive high cycles.
- Overlap mode:
  - overlap_en=1: fill is not altered on a match, so suffix bits can start the next match.
  - overlap_en=0: on a match, fill_next is forced to 0. The next detection needs len fresh bits.
  - overlap_en is sampled every cycle; changing it mid-stream affects only the next match decision.
- Counter:
  - Increments by 1 on each match; saturates at 2^COUNT_W-1 and does not wrap.
  - count_clear=1 sets it to 0 and wins over a simultaneous match.
- Length 1 pattern: every sampled bit equal to pattern[0] is a detection in either mode.

Optional Feature:
- Macro: SEQDET_MATCH_COUNT_EN.
- Defined: match_count, its saturation logic and count_clear behave as described above.
- Undefined: counter logic is not built, match_count is tied to 0, and count_clear is ignored. All other behaviour is identical.

Test Plan:
- Reset/defaults: hold reset low 3 cycles, then release, then apply stream 1,0,1,1 with valid=1 -> detector_out=1 for exactly one cycle, in the cycle after the 4th bit edge; match_count=1.
- Overlap: pattern 1011, len 4, overlap_en=1, stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; match_count=2.
- Non-overlap: same pattern, overlap_en=0, stream 1,0,1,1,0,1,1 -> one pulse (bit 4). Then stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8; match_count=2.
- Valid gaps and reload:
  - Stream 1,0,1,1 with valid low for 2 cycles between bits 2 and 3 -> one pulse after bit 4 arrives.
  - cfg_load with cfg_pattern=8'hA5, cfg_len=8 mid-stream -> counter cleared, no pulse until 8 new bits 1,0,1,0,0,1,0,1 have been received.
- Saturation and clear:
  - COUNT_W=2, len=1, pattern 1, stream of 5 ones -> match_count reaches 3 and holds.
  - count_clear coincident with a match -> match_count=0 while detector_out still pulses.
  - Reset asserted mid-match -> detector_out and match_count drop to 0 immediately, without waiting for a clock edge.
- Edge lengths: cfg_len=0 with any stream -> detector_out never asserts. cfg_len=15 with MAX_LEN=8 -> behaves as len=8.
